ym_clk_gen: RTL and testbench

YM_CLK_GEN -- requirements
Module: ym_clk_gen

---
 rtl/ym_clk_gen.sv | 176 +++++++++++++++++
 tb/tb_ym_clk_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_clk_gen.sv
// ym_clk_gen: programmable clock divider producing ym_pm with a coincident
// ym_cen strobe, supporting free-run and counted burst (step) modes, plus a
// wrap-flagged event counter of ym_pm rising edges.
// Optional feature: define YM_CLK_GEN_SNAPSHOT_EN to make snap capture the
// event counter into snap_q; otherwise snap is ignored and snap_q reads 0.
module ym_clk_gen #(
    parameter int DIV_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] period,
    input  logic [DIV_W-1:0] high_len,
    input  logic             cfg_load,
    input  logic             run,
    input  logic             step_go,
    input  logic [7:0]       step_n,
    input  logic             rst_counter,
    input  logic             irq_n,
    input  logic             snap,
    output logic             ym_pm,
    output logic             ym_cen,
    output logic             step_done,
    output logic             busy,
    output logic [CNT_W-1:0] pm_counter,
    output logic             cnt_ovf,
    output logic [CNT_W-1:0] snap_q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] r_period_q;
    logic [DIV_W-1:0] r_high_q;
    logic             r_cfg_pend;
    logic [7:0]       r_step_cnt;
    logic             r_pm_d;

    logic             w_tc;
    logic             w_cfg_req;
    logic             w_rise;

    // Terminal count uses >= so a shrunken period can never strand the divider.
    assign w_tc      = (r_div_cnt >= r_period_q);
    assign w_cfg_req = r_cfg_pend | cfg_load;
    assign w_rise    = ym_pm & ~r_pm_d;

    // Shadow configuration: adopt new period/high only at a period boundary or while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_q <= DIV_W'(4);
            r_high_q   <= DIV_W'(2);
            r_cfg_pend <= 1'b0;
        end else if (w_cfg_req && (w_tc || (r_state == ST_IDLE))) begin
            r_period_q <= period;
            r_high_q   <= high_len;
            r_cfg_pend <= 1'b0;
        end else begin
            r_cfg_pend <= w_cfg_req;
        end
    end

    // Mode FSM and divider: generates ym_pm, ym_cen, step_done and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= {DIV_W{1'b0}};
            r_step_cnt <= 8'd0;
            ym_pm      <= 1'b0;
            ym_cen     <= 1'b0;
            step_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ym_cen    <= 1'b0;
            step_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_div_cnt <= {DIV_W{1'b0}};
                    ym_pm     <= 1'b0;
                    if (run) begin
                        r_state <= ST_RUN;
                        busy    <= 1'b1;
                    end else if (step_go && (step_n != 8'd0)) begin
                        r_state    <= ST_STEP;
                        r_step_cnt <= step_n;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (w_tc) begin
                        r_div_cnt <= {DIV_W{1'b0}};
                        if ((r_state == ST_RUN) && !run) begin
                            // Free-run stops only on a period boundary, without a pulse.
                            r_state <= ST_IDLE;
                            ym_pm   <= 1'b0;
                            busy    <= 1'b0;
                        end else if ((r_state == ST_STEP) && (r_step_cnt == 8'd0)) begin
                            // Last burst period has completed.
                            r_state   <= ST_IDLE;
                            ym_pm     <= 1'b0;
                            busy      <= 1'b0;
                            step_done <= 1'b1;
                        end else begin
                            ym_pm  <= 1'b1;
                            ym_cen <= 1'b1;
                            if (r_state == ST_STEP) begin
                                r_step_cnt <= r_step_cnt - 8'd1;
                            end
                        end
                    end else if (r_div_cnt == r_high_q) begin
                        ym_pm     <= 1'b0;
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_div_cnt <= {DIV_W{1'b0}};
                    ym_pm     <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Event counter: counts registered ym_pm rising edges gated by irq_n; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pm_d     <= 1'b0;
            pm_counter <= {CNT_W{1'b0}};
            cnt_ovf    <= 1'b0;
        end else begin
            r_pm_d <= ym_pm;
            if (rst_counter) begin
                pm_counter <= {CNT_W{1'b0}};
                cnt_ovf    <= 1'b0;
            end else if (w_rise && irq_n) begin
                if (pm_counter == {CNT_W{1'b1}}) begin
                    pm_counter <= {CNT_W{1'b0}};
                    cnt_ovf    <= 1'b1;
                end else begin
                    pm_counter <= pm_counter + CNT_W'(1);
                end
            end
        end
    end

`ifdef YM_CLK_GEN_SNAPSHOT_EN
    // Snapshot: capture the counter value as it was before this edge's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= {CNT_W{1'b0}};
        end else if (snap) begin
            snap_q <= pm_counter;
        end
    end
`else
    // Snapshot disabled: snap_q is held at zero and snap has no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= {CNT_W{1'b0}};
        end else begin
            snap_q <= {CNT_W{1'b0}} & {CNT_W{snap}};
        end
    end
`endif

endmodule

// File: tb/tb_ym_clk_gen.sv
// Testbench for ym_clk_gen: directed scenarios plus a randomized phase, all
// checked every cycle against an event-scheduling reference model.
module tb_ym_clk_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  period = 5'd0;
    logic [4:0]  high_len = 5'd0;
    logic        cfg_load = 1'b0;
    logic        run = 1'b0;
    logic        step_go = 1'b0;
    logic [7:0]  step_n = 8'd0;
    logic        rst_counter = 1'b0;
    logic        irq_n = 1'b1;
    logic        snap = 1'b0;

    logic        ym_pm, ym_cen, step_done, busy, cnt_ovf;
    logic [31:0] pm_counter, snap_q;
    logic        ym_pm4, ym_cen4, step_done4, busy4, cnt_ovf4;
    logic [3:0]  pm_counter4, snap_q4;

    ym_clk_gen dut (
        .clk(clk), .rst(rst), .period(period), .high_len(high_len),
        .cfg_load(cfg_load), .run(run), .step_go(step_go), .step_n(step_n),
        .rst_counter(rst_counter), .irq_n(irq_n), .snap(snap),
        .ym_pm(ym_pm), .ym_cen(ym_cen), .step_done(step_done), .busy(busy),
        .pm_counter(pm_counter), .cnt_ovf(cnt_ovf), .snap_q(snap_q)
    );

    ym_clk_gen #(.DIV_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .period(period), .high_len(high_len),
        .cfg_load(cfg_load), .run(run), .step_go(step_go), .step_n(step_n),
        .rst_counter(rst_counter), .irq_n(irq_n), .snap(snap),
        .ym_pm(ym_pm4), .ym_cen(ym_cen4), .step_done(step_done4), .busy(busy4),
        .pm_counter(pm_counter4), .cnt_ovf(cnt_ovf4), .snap_q(snap_q4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: absolute-time schedule of period boundaries and falls.
    longint      cyc;
    int          m_mode;      // 0 idle, 1 free run, 2 burst
    longint      m_bound;     // cycle of next terminal count
    longint      m_fall;      // cycle at which ym_pm drops, -1 if none
    int          m_P, m_H, m_left;
    bit          m_pend, m_pm, m_pm_d, m_cen, m_done, m_ovf, m_ovf4;
    logic [31:0] m_cnt, m_snap;
    logic [3:0]  m_cnt4, m_snap4;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_bound = 0; m_fall = -1; m_P = 4; m_H = 2; m_left = 0;
        m_pend = 0; m_pm = 0; m_pm_d = 0; m_cen = 0; m_done = 0;
        m_cnt = 32'd0; m_cnt4 = 4'd0; m_ovf = 0; m_ovf4 = 0;
        m_snap = 32'd0; m_snap4 = 4'd0;
    endtask

    task automatic model_edge();
        bit rise, req;
        cyc++;
        m_cen = 0; m_done = 0;
        rise = m_pm && !m_pm_d;
`ifdef YM_CLK_GEN_SNAPSHOT_EN
        if (snap) begin m_snap = m_cnt; m_snap4 = m_cnt4; end
`endif
        if (rst_counter) begin
            m_cnt = 32'd0; m_cnt4 = 4'd0; m_ovf = 0; m_ovf4 = 0;
        end else if (rise && irq_n) begin
            if (m_cnt == 32'hFFFF_FFFF) m_ovf = 1;
            if (m_cnt4 == 4'hF) m_ovf4 = 1;
            m_cnt = m_cnt + 32'd1;
            m_cnt4 = m_cnt4 + 4'd1;
        end
        m_pm_d = m_pm;
        req = m_pend || cfg_load;
        if (m_mode == 0) begin
            if (req) begin m_P = int'(period); m_H = int'(high_len); end
            m_pend = 0;
            if (run) begin
                m_mode = 1; m_bound = cyc + m_P + 1; m_fall = -1;
            end else if (step_go && step_n != 8'd0) begin
                m_mode = 2; m_left = int'(step_n); m_bound = cyc + m_P + 1; m_fall = -1;
            end
        end else if (cyc == m_bound) begin
            if (req) begin m_P = int'(period); m_H = int'(high_len); end
            m_pend = 0;
            if (m_mode == 1 && !run) begin
                m_mode = 0; m_pm = 0;
            end else if (m_mode == 2 && m_left == 0) begin
                m_mode = 0; m_pm = 0; m_done = 1;
            end else begin
                m_pm = 1; m_cen = 1;
                if (m_mode == 2) m_left--;
                m_bound = cyc + m_P + 1;
                m_fall = (m_H < m_P) ? cyc + m_H + 1 : -1;
            end
        end else begin
            m_pend = req;
            if (cyc == m_fall) m_pm = 0;
        end
    endtask

    task automatic check_all();
        chk("ym_pm", ym_pm, m_pm);
        chk("ym_cen", ym_cen, m_cen);
        chk("step_done", step_done, m_done);
        chk("busy", busy, m_mode != 0);
        chk("pm_counter", pm_counter, m_cnt);
        chk("cnt_ovf", cnt_ovf, m_ovf);
        chk("snap_q", snap_q, m_snap);
        chk("ym_pm_w4", ym_pm4, m_pm);
        chk("pm_counter_w4", pm_counter4, m_cnt4);
        chk("cnt_ovf_w4", cnt_ovf4, m_ovf4);
        chk("snap_q_w4", snap_q4, m_snap4);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    int  cen_cnt, done_cnt;
    bit  found;

    initial begin
        cyc = 0;
        model_reset();
        #1;
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_pm", ym_pm, 0);
        chk("rst_cnt", pm_counter, 0);
        chk("rst_snap", snap_q, 0);

        // Default configuration free run: 5-cycle period, 10 counted rises.
        run = 1'b1;
        repeat (52) tick();
        chk("default_10_rises", pm_counter, 10);

        // Mid-period reconfiguration to period 15 / high 7.
        repeat (2) tick();
        period = 5'd15; high_len = 5'd7; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (60) tick();

        // irq_n gating, clear-vs-increment priority, and 4-bit wrap.
        do_reset();
        run = 1'b1;
        for (int t = 1; t <= 125; t++) begin
            irq_n = !(t == 12 || t == 27);
            rst_counter = (t == 37) || (t == 123);
            tick();
            if (t == 32) chk("irq_gated_cnt", pm_counter, 4);
            if (t == 37) chk("clr_priority", pm_counter, 0);
            if (t == 121) chk("w4_wrapped_ovf", cnt_ovf4, 1);
            if (t == 122) begin
                chk("w4_17_rises", pm_counter4, 1);
                chk("w4_ovf_sticky", cnt_ovf4, 1);
                chk("w32_17_rises", pm_counter, 17);
            end
            if (t == 123) chk("w4_ovf_cleared", cnt_ovf4, 0);
        end
        irq_n = 1'b1; rst_counter = 1'b0;

        // Snapshot at count 7 coincident with an increment.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_cnt == 32'd7 && m_pm && !m_pm_d) found = 1;
            else tick();
        end
        chk("snap_found", found, 1);
        snap = 1'b1;
        tick();
        snap = 1'b0;
`ifdef YM_CLK_GEN_SNAPSHOT_EN
        chk("snap_value", snap_q, 7);
`else
        chk("snap_value", snap_q, 0);
`endif
        chk("snap_cnt_after", pm_counter, 8);

        // Stop free run, then burst with step_n=0 and step_n=3.
        run = 1'b0;
        for (int i = 0; i < 100 && m_mode != 0; i++) tick();
        chk("idle_wait", busy, 0);
        step_n = 8'd0; step_go = 1'b1;
        tick();
        step_go = 1'b0;
        repeat (8) tick();
        chk("step0_no_busy", busy, 0);
        step_n = 8'd3; step_go = 1'b1;
        tick();
        step_go = 1'b0;
        cen_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 100 && done_cnt == 0; i++) begin
            tick();
            if (ym_cen) cen_cnt++;
            if (step_done) begin
                done_cnt++;
                chk("busy_falls_with_done", busy, 0);
            end
        end
        repeat (5) tick();
        chk("burst_cen_count", cen_cnt, 3);
        chk("burst_done_count", done_cnt, 1);

        // Reset in the middle of a burst: no step_done.
        step_n = 8'd5; step_go = 1'b1;
        tick();
        step_go = 1'b0;
        repeat (7) tick();
        do_reset();
        chk("abort_done", step_done, 0);
        chk("abort_busy", busy, 0);
        repeat (10) tick();

        // Randomized phase.
        for (int i = 0; i < 1500; i++) begin
            cfg_load = ($urandom_range(0, 7) == 0);
            if (cfg_load) begin
                period = 5'($urandom_range(0, 12));
                high_len = 5'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 39) == 0) run = ~run;
            step_go = ($urandom_range(0, 9) == 0);
            step_n = 8'($urandom_range(0, 4));
            irq_n = ($urandom_range(0, 7) != 0);
            rst_counter = ($urandom_range(0, 63) == 0);
            snap = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
